// File: rtl/booth_op_sequencer.sv
// Operand/result handshake controller for the Booth radix-4 multiplier reg_file:
// drives start/inbus (multiplicand, then multiplier), collects outbus words, times out.
module booth_op_sequencer #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 9,
  parameter int RES_WORDS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [DATA_W-1:0]          op_a,
  input  logic [DATA_W-1:0]          op_b,
  output logic                       mul_start,
  output logic [DATA_W-1:0]          mul_inbus,
  input  logic                       mul_final,
  input  logic [OUT_W-1:0]           mul_outbus,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RES_WORDS*OUT_W-1:0] res_data,
  output logic                       res_err
);
  localparam int               IDX_W    = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_WORDS - 1);
  localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_W-1:0]          a_q, a_d, b_q, b_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       op_ready_q, op_ready_d;
  logic                       mul_start_q, mul_start_d;
  logic [DATA_W-1:0]          mul_inbus_q, mul_inbus_d;
  logic                       res_valid_q, res_valid_d;
  logic [RES_WORDS*OUT_W-1:0] res_data_q, res_data_d;
  logic                       res_err_q, res_err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_START;
        end
      end
      S_START:  state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // word0 is the outbus value in the same cycle mul_final is first seen
        if (mul_final) begin
          res_data_d[OUT_W-1:0] = mul_outbus;
          res_err_d             = 1'b0;
          idx_d                 = IDX_W'(1);
          state_d               = (LAST_IDX == '0) ? S_DONE : S_COLLECT;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = sat_inc(cnt_q, CNT_LAST);
        end
      end
      S_COLLECT: begin
        for (int w = 0; w < RES_WORDS; w++) begin
          if (idx_q == IDX_W'(w)) res_data_d[w*OUT_W +: OUT_W] = mul_outbus;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    op_ready_d  = (state_d == S_IDLE);
    mul_start_d = state_d inside {S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_COLLECT};
    res_valid_d = (state_d == S_DONE);
    mul_inbus_d = '0;
    case (state_d)
      S_LOAD_A:                   mul_inbus_d = a_q;
      S_LOAD_B, S_WAIT, S_COLLECT: mul_inbus_d = b_q;
      default:                    mul_inbus_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      op_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      mul_inbus_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      op_ready_q  <= op_ready_d;
      mul_start_q <= mul_start_d;
      mul_inbus_q <= mul_inbus_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign mul_start = mul_start_q;
  assign mul_inbus = mul_inbus_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Directed bench for booth_op_sequencer: table-driven operations plus hand-written
// backpressure, timeout, async-reset, back-to-back and spurious-final sequences.
module tb_booth_op_sequencer;
  localparam int DATA_W    = 8;
  localparam int OUT_W     = 9;
  localparam int RES_WORDS = 2;
  localparam int TIMEOUT   = 64;
  localparam int RW        = RES_WORDS * OUT_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic              mul_start;
  logic [DATA_W-1:0] mul_inbus;
  logic              mul_final;
  logic [OUT_W-1:0]  mul_outbus;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_data;
  logic              res_err;

  booth_op_sequencer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .RES_WORDS(RES_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mul_start(mul_start), .mul_inbus(mul_inbus),
    .mul_final(mul_final), .mul_outbus(mul_outbus), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [17:0] exp;   // expected res_data = {word1, word0} = a*b
    int          fdly;  // WAIT cycles before the model raises mul_final
    int          hold;  // cycles res_ready stays low in DONE
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("op_ready_wait", op_ready, 1);
  endtask

  // One full operation; the multiplier model returns v.exp as two outbus words.
  task automatic run_op(input vec_t v, input bit keep, input logic [7:0] na,
                        input logic [7:0] nb, input bit spur);
    wait_ready();
    op_valid = 1'b1;
    op_a     = v.a;
    op_b     = v.b;
    if (spur) mul_final = 1'b1;
    tick();
    mul_final = 1'b0;
    if (keep) begin
      op_a = na;
      op_b = nb;
    end else begin
      op_valid = 1'b0;
    end
    check("start_mul_start", mul_start, 1);
    check("start_inbus", mul_inbus, 0);
    check("busy_op_ready", op_ready, 0);
    tick();
    check("load_a_inbus", mul_inbus, v.a);
    check("load_a_start", mul_start, 1);
    if (spur) mul_final = 1'b1;
    tick();
    mul_final = 1'b0;
    check("load_b_inbus", mul_inbus, v.b);
    check("load_b_no_valid", res_valid, 0);
    tick();
    check("wait_inbus", mul_inbus, v.b);
    check("wait_start", mul_start, 1);
    for (int i = 0; i < v.fdly; i++) tick();
    mul_final  = 1'b1;
    mul_outbus = v.exp[8:0];
    tick();
    mul_final  = 1'b0;
    mul_outbus = v.exp[17:9];
    check("collect_no_valid", res_valid, 0);
    tick();
    mul_outbus = '0;
    check("done_res_valid", res_valid, 1);
    check("done_res_data", res_data, v.exp);
    check("done_res_err", res_err, 0);
    check("done_mul_start", mul_start, 0);
    check("done_op_ready", op_ready, 0);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, v.exp);
      check("hold_op_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release_res_valid", res_valid, 0);
    check("release_op_ready", op_ready, 1);
  endtask

  vec_t vecs[4];
  vec_t b2b[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd6,   8'd8,   18'h00030, 2, 0};
    vecs[1] = '{8'd6,   8'd8,   18'h00030, 0, 10};
    vecs[2] = '{8'd255, 8'd255, 18'h0FE01, 5, 1};
    vecs[3] = '{8'd200, 8'd100, 18'h04E20, 1, 0};
    b2b[0]  = '{8'd6,   8'd8,   18'h00030, 1, 0};
    b2b[1]  = '{8'd15,  8'd10,  18'h00096, 1, 0};
    b2b[2]  = '{8'd7,   8'd6,   18'h0002A, 1, 0};
    b2b[3]  = '{8'd255, 8'd1,   18'h000FF, 1, 0};

    reset = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    mul_final = 1'b0; mul_outbus = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_op_ready", op_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_inbus", mul_inbus, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    #2 reset = 1'b1;
    tick();
    check("post_rst_op_ready", op_ready, 1);

    // Spurious final in IDLE
    mul_final = 1'b1;
    repeat (3) tick();
    mul_final = 1'b0;
    check("spur_idle_op_ready", op_ready, 1);
    check("spur_idle_res_valid", res_valid, 0);
    check("spur_idle_mul_start", mul_start, 0);

    for (int i = 0; i < 4; i++) run_op(vecs[i], 1'b0, 8'd0, 8'd0, (i == 3));

    // Timeout: final never arrives
    wait_ready();
    op_valid = 1'b1; op_a = 8'd3; op_b = 8'd5;
    tick();
    op_valid = 1'b0;
    repeat (3) tick();
    check("to_wait_start", mul_start, 1);
    repeat (TIMEOUT - 1) tick();
    check("to_early_valid", res_valid, 0);
    tick();
    check("to_res_valid", res_valid, 1);
    check("to_res_err", res_err, 1);
    check("to_res_data", res_data, 0);
    check("to_mul_start", mul_start, 0);
    check("to_mul_inbus", mul_inbus, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("to_clear_valid", res_valid, 0);
    check("to_clear_err", res_err, 0);
    check("to_op_ready", op_ready, 1);

    // Asynchronous reset during WAIT
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    tick();
    op_valid = 1'b0;
    repeat (4) tick();
    check("mid_wait_start", mul_start, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_mul_start", mul_start, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_op_ready", op_ready, 0);
    check("arst_mul_inbus", mul_inbus, 0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    check("arst_release_ready", op_ready, 1);
    run_op(b2b[1], 1'b0, 8'd0, 8'd0, 1'b0);

    // Back-to-back with op_valid held high
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (i < 3) ? i + 1 : i;
      run_op(b2b[i], (i < 3), b2b[j].a, b2b[j].b, (i == 1));
    end
    tick();
    check("b2b_idle_ready", op_ready, 1);
    check("b2b_idle_start", mul_start, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
